reg_file_unit: RTL and testbench
================================

Name: reg_file_unit

Overview:
- General-register file for the VCPU-32 pipeline.
- SIZE registers of WIDTH bits, with two combinational read ports (A, B) and one synchronous write port.
- Feeds operand fetch and is written at retire.
- Register 0 is hardwired to zero.
- Write-to-read bypass on both read ports, so a retire and a fetch to the same register in one cycle need no extra forwarding logic.

Parameters:
- WIDTH, 32: register width in bits. Bit 0 is the MSB.
- SIZE, 8: number of registers. Power of two, at least 2. Address width AW = clog2(SIZE).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-low.
- write  input  1  write enable, sampled on the rising clk edge.
- wrAddr  input  AW  write register index.
- wrData  input  WIDTH  write data.
- rdAddrA  input  AW  read port A register index.
- rdAddrB  input  AW  read port B register index.
- rdDataA  output  WIDTH  read port A data, combinational.
- rdDataB  output  WIDTH  read port B data, combinational.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst).
- Reset entry: rst=0 clears registers 1..SIZE-1 to 0 immediately, independent of clk.
  - While rst=0, rdDataA and rdDataB are 0 and writes are ignored.
- Reset mid-write: rst falling in the same cycle as a pending write means the write is lost.
- Reset release: after rst returns to 1, the first rising edge with write=1 is a valid write.
- Write: on the rising edge of clk with rst=1, write=1 and wrAddr!=0, reg[wrAddr] <= wrData.
  - Latency is 1 cycle; the new value is visible in the array after that edge.
- Register 0: writes to index 0 are discarded. Reads of index 0 always return 0, including under bypass.
- Read: rdDataX = reg[rdAddrX], purely combinational, with zero cycles of latency from an address change.
- Bypass: if rst=1, write=1, wrAddr==rdAddrX and wrAddr!=0, then rdDataX = wrData in the same cycle, before the clock edge. Applies independently to port A and port B.
- Dual read: rdAddrA==rdAddrB is legal and both ports return identical data.
- write=0: no register changes. wrAddr and wrData are don't-care.
- X handling: unknown or out-of-range addresses cannot occur because SIZE is a power of two. No error output.
- Storage: flop array with synchronous write and asynchronous clear. No tristates and no latches.

Test Plan:
1. Reset: preload registers with nonzero values, drive rst=0 mid-cycle → all read ports return 0x00000000 immediately, before any clk edge. Release rst=1 → every register 1..7 reads 0.
2. Write/read: write 0xDEADBEEF to reg 3 and 0x12345678 to reg 7 on successive edges, then set rdAddrA=3, rdAddrB=7 → rdDataA=0xDEADBEEF, rdDataB=0x12345678. write=0 with wrAddr=3, wrData=0xFFFFFFFF → reg 3 is unchanged.
3. Register 0: write 0xFFFFFFFF to reg 0, read A=0 and B=0 → both read 0, also while write=1 with wrAddr=0 is held (no bypass).
4. Bypass: reg 5 holds 0x11111111; drive write=1, wrAddr=5, wrData=0xA5A5A5A5, rdAddrA=5, rdAddrB=5.
   - Before the edge, both ports read 0xA5A5A5A5.
   - After the edge with write=0, both still read 0xA5A5A5A5.
   - With rdAddrB=4 instead, port B shows reg 4 and is unaffected by the bypass.
5. Async reset during write: rst=0 asserted half a cycle before an edge with write=1, wrAddr=2, wrData=0x55 → after release, reg 2 reads 0. Outputs are 0 while rst=0 even with the bypass condition true.
6. Full sweep: write value (i*0x01010101) to regs 1..7, then read all pairs (i, 7-i) → the exact stored values appear on each port, and reg 0 reads 0.

Source files
------------

// File: rtl/reg_file_unit.sv
// Purpose: general-register file, SIZE x WIDTH, two combinational read ports, one write port, r0 reads as zero.
// Latency: reads are combinational (0 cycles); writes land on the next rising clk edge, bypassed to matching read ports.
// Backpressure: none; a write is accepted every cycle it is presented and reads are always valid.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-low reset; clears r1..rN and forces both read ports to 0
//   write            write enable
//   wrAddr, wrData   write index / data (writes to index 0 are dropped)
//   rdAddrA/B        read indices
//   rdDataA/B        read data, with same-cycle write bypass
module reg_file_unit #(
    parameter  int WIDTH = 32,
    parameter  int SIZE  = 8,
    localparam int AW    = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic [AW-1:0]    wrAddr,
    input  logic [0:WIDTH-1] wrData,
    input  logic [AW-1:0]    rdAddrA,
    input  logic [AW-1:0]    rdAddrB,
    output logic [0:WIDTH-1] rdDataA,
    output logic [0:WIDTH-1] rdDataB
);

    // Register 0 has no storage: it is a constant zero.
    logic [0:WIDTH-1] r_regs [1:SIZE-1];

    logic w_wr_en;
    logic w_byp_a;
    logic w_byp_b;
    logic [0:WIDTH-1] w_rd_a;
    logic [0:WIDTH-1] w_rd_b;

    assign w_wr_en = write && (wrAddr != '0);

    // Bypass only while out of reset; reset must win so outputs read 0.
    assign w_byp_a = rst && w_wr_en && (wrAddr == rdAddrA);
    assign w_byp_b = rst && w_wr_en && (wrAddr == rdAddrB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < SIZE; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[wrAddr] <= wrData;
        end
    end

    always_comb begin
        w_rd_a = '0;
        if (rst && (rdAddrA != '0)) begin
            w_rd_a = w_byp_a ? wrData : r_regs[rdAddrA];
        end
    end

    always_comb begin
        w_rd_b = '0;
        if (rst && (rdAddrB != '0)) begin
            w_rd_b = w_byp_b ? wrData : r_regs[rdAddrB];
        end
    end

    assign rdDataA = w_rd_a;
    assign rdDataB = w_rd_b;

endmodule

// File: tb/tb_reg_file_unit.sv
// Purpose: directed self-checking bench for reg_file_unit with an expectation queue.
// Latency: expectations are pushed when read addresses are driven and popped 1ns later.
// Backpressure: not applicable.
module tb_reg_file_unit;

    logic        clk;
    logic        rst;
    logic        write;
    logic [2:0]  wrAddr;
    logic [31:0] wrData;
    logic [2:0]  rdAddrA;
    logic [2:0]  rdAddrB;
    logic [31:0] rdDataA;
    logic [31:0] rdDataB;

    int tests;
    int fails;

    typedef struct {
        string       tag;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [0:7];

    reg_file_unit #(.WIDTH(32), .SIZE(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .write   (write),
        .wrAddr  (wrAddr),
        .wrData  (wrData),
        .rdAddrA (rdAddrA),
        .rdAddrB (rdAddrB),
        .rdDataA (rdDataA),
        .rdDataB (rdDataB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #90000;
        $display("FAIL timeout: simulation did not finish (tests=%0d fails=%0d)", tests, fails);
        $fatal(1);
    end

    // Push an expectation computed from the bench's own register model.
    task automatic drive_rd(input string tag, input logic [2:0] a, input logic [2:0] b);
        exp_t e;
        rdAddrA = a;
        rdAddrB = b;
        e.tag   = tag;
        e.exp_a = model[a];
        e.exp_b = model[b];
        sb_q.push_back(e);
    endtask

    // Push an explicit expectation (bypass / reset cases the model does not cover).
    task automatic drive_exp(input string tag, input logic [2:0] a, input logic [2:0] b,
                             input logic [31:0] ea, input logic [31:0] eb);
        exp_t e;
        rdAddrA = a;
        rdAddrB = b;
        e.tag   = tag;
        e.exp_a = ea;
        e.exp_b = eb;
        sb_q.push_back(e);
    endtask

    // Let combinational outputs settle, then pop and compare both ports.
    task automatic sample();
        exp_t e;
        #1;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb_q.pop_front();
        tests++;
        assert (rdDataA === e.exp_a) else begin
            fails++;
            $error("FAIL %s portA: got %h expected %h", e.tag, rdDataA, e.exp_a);
        end
        tests++;
        assert (rdDataB === e.exp_b) else begin
            fails++;
            $error("FAIL %s portB: got %h expected %h", e.tag, rdDataB, e.exp_b);
        end
    endtask

    // One write through a rising edge; model tracks what the DUT should hold.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        write  = 1'b1;
        wrAddr = a;
        wrData = d;
        @(posedge clk);
        if (rst && a != 3'd0) model[a] = d;
        #1;
        write = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        write   = 1'b0;
        wrAddr  = 3'd0;
        wrData  = 32'h0;
        rdAddrA = 3'd0;
        rdAddrB = 3'd0;
        clear_model();

        // Reset state
        #2 rst = 1'b0;
        drive_exp("reset_state", 3'd1, 3'd7, 32'h0, 32'h0);
        sample();
        @(negedge clk);
        rst = 1'b1;
        drive_rd("post_reset_r1_r7", 3'd1, 3'd7);
        sample();

        // 1. Preload, then asynchronous reset mid-cycle
        for (int i = 1; i < 8; i++) wr(3'(i), 32'h11111111 * i);
        drive_rd("preload_r3_r7", 3'd3, 3'd7);
        sample();
        @(negedge clk);
        #2 rst = 1'b0;
        clear_model();
        drive_exp("async_reset_immediate", 3'd3, 3'd7, 32'h0, 32'h0);
        sample();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i < 8; i++) begin
            drive_rd("after_reset_sweep", 3'(i), 3'(i));
            sample();
        end

        // 2. Write / read, and write=0 leaves contents alone
        wr(3'd3, 32'hDEADBEEF);
        wr(3'd7, 32'h12345678);
        drive_rd("write_read_3_7", 3'd3, 3'd7);
        sample();
        @(negedge clk);
        write  = 1'b0;
        wrAddr = 3'd3;
        wrData = 32'hFFFFFFFF;
        drive_rd("we0_no_bypass", 3'd3, 3'd3);
        sample();
        @(posedge clk);
        #1;
        drive_rd("we0_no_change", 3'd3, 3'd7);
        sample();

        // 3. Register 0 ignores writes and never bypasses
        @(negedge clk);
        write  = 1'b1;
        wrAddr = 3'd0;
        wrData = 32'hFFFFFFFF;
        drive_exp("r0_held_write", 3'd0, 3'd0, 32'h0, 32'h0);
        sample();
        @(posedge clk);
        #1;
        drive_exp("r0_after_edge", 3'd0, 3'd0, 32'h0, 32'h0);
        sample();
        write = 1'b0;
        drive_rd("r0_idle", 3'd0, 3'd0);
        sample();

        // 4. Bypass on both ports, then independence of port B
        wr(3'd5, 32'h11111111);
        wr(3'd4, 32'h44444444);
        @(negedge clk);
        write  = 1'b1;
        wrAddr = 3'd5;
        wrData = 32'hA5A5A5A5;
        drive_exp("bypass_both_pre_edge", 3'd5, 3'd5, 32'hA5A5A5A5, 32'hA5A5A5A5);
        sample();
        @(posedge clk);
        model[5] = 32'hA5A5A5A5;
        #1;
        write = 1'b0;
        drive_rd("bypass_both_post_edge", 3'd5, 3'd5);
        sample();
        @(negedge clk);
        write  = 1'b1;
        wrAddr = 3'd5;
        wrData = 32'h5A5A5A5A;
        drive_exp("bypass_a_only", 3'd5, 3'd4, 32'h5A5A5A5A, 32'h44444444);
        sample();
        write = 1'b0;
        drive_rd("bypass_dropped", 3'd5, 3'd4);
        sample();

        // 5. Reset asserted half a cycle before a write edge loses the write
        @(negedge clk);
        write  = 1'b1;
        wrAddr = 3'd2;
        wrData = 32'h00000055;
        drive_exp("bypass_before_reset", 3'd2, 3'd2, 32'h55, 32'h55);
        sample();
        rst = 1'b0;
        clear_model();
        drive_exp("reset_masks_bypass", 3'd2, 3'd2, 32'h0, 32'h0);
        sample();
        @(posedge clk);
        #1;
        drive_exp("reset_edge_no_write", 3'd2, 3'd2, 32'h0, 32'h0);
        sample();
        @(negedge clk);
        rst   = 1'b1;
        write = 1'b0;
        drive_rd("lost_write_r2", 3'd2, 3'd5);
        sample();
        wr(3'd2, 32'h00000066);
        drive_rd("first_write_after_release", 3'd2, 3'd2);
        sample();

        // 6. Full sweep of distinct values with mirrored read pairs
        for (int i = 1; i < 8; i++) wr(3'(i), 32'h01010101 * i);
        for (int i = 0; i < 8; i++) begin
            drive_rd("sweep_pairs", 3'(i), 3'(7 - i));
            sample();
        end

        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_leftover: %0d expectations left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
